// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM state type and scan-code prefix constants
// for the PS/2 key-event path.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_POP    = 2'd1,
    S_SETTLE = 2'd2
  } ps2_state_e;

  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;

endpackage

// File: rtl/bcd_cnt2.sv
// bcd_cnt2: two-digit BCD up-counter, {tens,ones}, wraps 99 -> 00.
// Synchronous active-high reset.
module bcd_cnt2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] bcd
);

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd <= 8'h00;
    end else if (inc) begin
      if (bcd[3:0] == 4'd9) begin
        bcd[3:0] <= 4'd0;
        bcd[7:4] <= (bcd[7:4] == 4'd9) ? 4'd0 : bcd[7:4] + 4'd1;
      end else begin
        bcd[3:0] <= bcd[3:0] + 4'd1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: pops the PS/2 FIFO and turns scan codes into key events.
// Define PS2_KEY_EXT_EN to honour the E0 extended prefix.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int CNT_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ps2_ready,
  input  logic [7:0]              ps2_data,
  input  logic                    ps2_overflow,
  output logic                    nextdata_n,
  output logic                    evt_valid,
  output logic [7:0]              evt_code,
  output logic                    evt_ext,
  output logic                    evt_break,
  output logic                    evt_repeat,
  output logic                    key_down,
  output logic [7:0]              held_code,
  output logic [4*CNT_DIGITS-1:0] press_bcd,
  output logic                    ovf_err
);

  ps2_state_e state;
  logic       brk_pend;
  logic       fire;
  logic       is_brk;
  logic       is_ext;
  logic       is_key;
  logic       same_id;
  logic       new_press;
  logic       rep_hit;
  logic       rel_hit;

  // Decode straight off the FIFO head; results are registered at the pop.
  assign fire      = (state == S_IDLE) && ps2_ready;
  assign is_brk    = (ps2_data == PS2_BRK);
  assign is_ext    = (ps2_data == PS2_EXT);
  assign is_key    = fire && !is_brk && !is_ext;
  assign new_press = is_key && !brk_pend && !same_id;
  assign rep_hit   = is_key && !brk_pend && same_id;
  assign rel_hit   = is_key && brk_pend && same_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      nextdata_n <= 1'b1;
      evt_valid  <= 1'b0;
      evt_code   <= 8'h00;
      evt_break  <= 1'b0;
      evt_repeat <= 1'b0;
      key_down   <= 1'b0;
      held_code  <= 8'h00;
      brk_pend   <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      evt_valid <= 1'b0;
      if (ps2_overflow) ovf_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (ps2_ready) begin
            state      <= S_POP;
            nextdata_n <= 1'b0;
          end
        end
        S_POP: begin
          state      <= S_SETTLE;
          nextdata_n <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          nextdata_n <= 1'b1;
        end
      endcase

      if (fire && is_brk) brk_pend <= 1'b1;

      if (is_key) begin
        brk_pend   <= 1'b0;
        evt_valid  <= 1'b1;
        evt_code   <= ps2_data;
        evt_break  <= brk_pend;
        evt_repeat <= rep_hit;
      end

      unique case (1'b1)
        new_press: begin
          key_down  <= 1'b1;
          held_code <= ps2_data;
        end
        rel_hit: key_down <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef PS2_KEY_EXT_EN
  logic ext_pend;
  logic held_ext;

  assign same_id = key_down && (held_code == ps2_data)
                && (held_ext == ext_pend);

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_pend <= 1'b0;
      held_ext <= 1'b0;
      evt_ext  <= 1'b0;
    end else begin
      if (fire && is_ext) ext_pend <= 1'b1;
      if (is_key) begin
        ext_pend <= 1'b0;
        evt_ext  <= ext_pend;
      end
      if (new_press) held_ext <= ext_pend;
    end
  end
`else
  // E0 is popped but otherwise invisible; identity is the code alone.
  assign same_id = key_down && (held_code == ps2_data);
  assign evt_ext = 1'b0;
`endif

  bcd_cnt2 u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (new_press),
    .bcd (press_bcd)
  );

endmodule
